// File: rtl/deserializer_ctrl.sv
// deserializer_ctrl: framing and flow controller for the NoC link deserializer.
// Narrow serial beats are shifted into a SIPO register and published as one
// wide flit on a valid/ready port. Framing errors raise a one-cycle pulse, and
// the serial side is backpressured only when a finished flit could not be stored.
module deserializer_ctrl #(
  parameter int INPUT_SIZE  = 4,
  parameter int OUTPUT_SIZE = 32,
  parameter int REQUIRE_SOF = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INPUT_SIZE-1:0]  in_data,
  input  logic                   in_valid,
  input  logic                   in_sof,
  output logic                   in_ready,
  output logic [OUTPUT_SIZE-1:0] flit_data,
  output logic                   flit_valid,
  input  logic                   flit_ready,
  output logic                   err_frame,
  output logic                   busy
);

  localparam int BEATS = OUTPUT_SIZE / INPUT_SIZE;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  // Register state
  logic [OUTPUT_SIZE-1:0] sreg_q,       sreg_d;
  logic [CNT_W-1:0]       beat_cnt_q,   beat_cnt_d;
  logic [OUTPUT_SIZE-1:0] flit_data_q,  flit_data_d;
  logic                   flit_valid_q, flit_valid_d;
  logic                   err_frame_q,  err_frame_d;

  // Combinational helpers
  logic                   acc_s;
  logic                   at_last_s;
  logic                   at_first_s;
  logic [OUTPUT_SIZE-1:0] shifted_s;

  assign at_last_s  = (beat_cnt_q == CNT_LAST);
  assign at_first_s = (beat_cnt_q == CNT_ZERO);

  // The only beat that cannot be taken is the final one of a flit while the
  // previously completed flit is still waiting and not being consumed now.
  assign in_ready  = ~reset & ~(flit_valid_q & ~flit_ready & at_last_s);
  assign acc_s     = in_valid & in_ready;

  // Newest beat enters at the MSB end so beat 0 ends up in the lowest bits.
  assign shifted_s = {in_data, sreg_q[OUTPUT_SIZE-1:INPUT_SIZE]};

  // Next-state: shifting, beat counting, framing checks and flit hand-off.
  always_comb begin
    sreg_d       = sreg_q;
    beat_cnt_d   = beat_cnt_q;
    flit_data_d  = flit_data_q;
    flit_valid_d = flit_valid_q;
    err_frame_d  = 1'b0;

    // A consumed flit is released unless a new one replaces it below.
    if (flit_valid_q && flit_ready) begin
      flit_valid_d = 1'b0;
    end else begin
      flit_valid_d = flit_valid_q;
    end

    if (acc_s) begin
      if (in_sof && !at_first_s) begin
        // Unexpected start of frame: abandon the partial flit and restart
        // with this beat as beat 0. Stale beats shift out naturally.
        err_frame_d = 1'b1;
        sreg_d      = shifted_s;
        beat_cnt_d  = CNT_ONE;
      end else if ((REQUIRE_SOF != 0) && at_first_s && !in_sof) begin
        // Unframed beat at idle is dropped without touching the register.
        err_frame_d = 1'b1;
        sreg_d      = sreg_q;
        beat_cnt_d  = beat_cnt_q;
      end else begin
        sreg_d = shifted_s;
        if (at_last_s) begin
          beat_cnt_d   = CNT_ZERO;
          flit_data_d  = shifted_s;
          flit_valid_d = 1'b1;
        end else begin
          beat_cnt_d   = beat_cnt_q + CNT_ONE;
        end
      end
    end else begin
      sreg_d     = sreg_q;
      beat_cnt_d = beat_cnt_q;
    end
  end

  // State register with synchronous reset; reset drops all in-flight data.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q       <= {OUTPUT_SIZE{1'b0}};
      beat_cnt_q   <= CNT_ZERO;
      flit_data_q  <= {OUTPUT_SIZE{1'b0}};
      flit_valid_q <= 1'b0;
      err_frame_q  <= 1'b0;
    end else begin
      sreg_q       <= sreg_d;
      beat_cnt_q   <= beat_cnt_d;
      flit_data_q  <= flit_data_d;
      flit_valid_q <= flit_valid_d;
      err_frame_q  <= err_frame_d;
    end
  end

  assign flit_data  = flit_data_q;
  assign flit_valid = flit_valid_q;
  assign err_frame  = err_frame_q;
  assign busy       = (beat_cnt_q != CNT_ZERO);

endmodule
